// File: rtl/gnrc_edge_pkg.sv
// Shared types and helpers for the gnrc_edge_event block.
// Optional input synchroniser is enabled with `define GNRC_EDGE_EVENT_SYNC_EN.
package gnrc_edge_pkg;

  typedef enum logic [1:0] {
    EDGE_NONE = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_mode_e;

  // Filter counter width; a zero-cycle filter still needs a 1-bit counter.
  function automatic int filt_cnt_width(input int filt);
    int w;
    w = $clog2(filt + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/gnrc_edge_filter.sv
// One channel of gnrc_edge_event: optional synchroniser, glitch filter, level and pulse flops.
// Synchroniser present only when GNRC_EDGE_EVENT_SYNC_EN is defined.
module gnrc_edge_filter
  import gnrc_edge_pkg::*;
#(
  parameter int   FILT_CYCLES = 3,
`ifdef GNRC_EDGE_EVENT_SYNC_EN
  parameter int   SYNC_STAGES = 2,
`endif
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int            CW      = filt_cnt_width(FILT_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(FILT_CYCLES);

  logic          raw;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;

`ifdef GNRC_EDGE_EVENT_SYNC_EN
  logic [SYNC_STAGES-1:0] sync_q, sync_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d_i};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign raw = sync_q[SYNC_STAGES-1];
`else
  assign raw = d_i;
`endif

  // A level change is accepted once raw has disagreed on FILT_CYCLES+1 consecutive edges.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (raw == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d   = '0;
      level_d = raw;
      rise_d  = raw;
      fall_d  = ~raw;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      level_q <= RST_VAL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/gnrc_edge_event.sv
// Multi-channel edge-event unit: per-channel filtered edges, sticky pending flags, OR-ed irq.
// Define GNRC_EDGE_EVENT_SYNC_EN to add a SYNC_STAGES-deep synchroniser on every d_i bit.
module gnrc_edge_event
  import gnrc_edge_pkg::*;
#(
  parameter int                NUM_CH      = 8,
  parameter int                FILT_CYCLES = 3,
  parameter int                SYNC_STAGES = 2,
  parameter logic [NUM_CH-1:0] RST_VAL     = '0
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NUM_CH-1:0]      d_i,
  input  logic [NUM_CH-1:0][1:0] mode_i,
  input  logic [NUM_CH-1:0]      clr_i,
  output logic [NUM_CH-1:0]      level_o,
  output logic [NUM_CH-1:0]      rise_o,
  output logic [NUM_CH-1:0]      fall_o,
  output logic [NUM_CH-1:0]      pend_o,
  output logic                   irq_o
);

  if (NUM_CH < 1 || FILT_CYCLES < 0 || SYNC_STAGES < 2) begin : g_bad_params
    $error("gnrc_edge_event: illegal parameter value");
  end

  logic [NUM_CH-1:0] set;
  logic [NUM_CH-1:0] pend_q, pend_d;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    gnrc_edge_filter #(
      .FILT_CYCLES (FILT_CYCLES),
`ifdef GNRC_EDGE_EVENT_SYNC_EN
      .SYNC_STAGES (SYNC_STAGES),
`endif
      .RST_VAL     (RST_VAL[c])
    ) u_filt (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .d_i     (d_i[c]),
      .level_o (level_o[c]),
      .rise_o  (rise_o[c]),
      .fall_o  (fall_o[c])
    );
  end

  // A new event takes priority over a clear arriving on the same edge.
  always_comb begin
    set    = '0;
    pend_d = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      set[c] = (rise_o[c] && (mode_i[c] == EDGE_RISE || mode_i[c] == EDGE_BOTH)) ||
               (fall_o[c] && (mode_i[c] == EDGE_FALL || mode_i[c] == EDGE_BOTH));
    end
    pend_d = set | (pend_q & ~clr_i);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  assign pend_o = pend_q;
  assign irq_o  = |pend_q;

endmodule

// File: tb/tb_gnrc_edge_event.sv
// Self-checking bench for gnrc_edge_event; honours GNRC_EDGE_EVENT_SYNC_EN for the expected latency.
module tb_gnrc_edge_event;
  import gnrc_edge_pkg::*;

  localparam int NC = 8;
  localparam int F  = 3;
`ifdef GNRC_EDGE_EVENT_SYNC_EN
  localparam int S  = 2;
`else
  localparam int S  = 0;
`endif
  localparam int LAT = S + F + 1;
  localparam logic [NC-1:0] RSTV = '0;

  logic               clk_i = 1'b0;
  logic               rst_ni;
  logic [NC-1:0]      d_i;
  logic [NC-1:0][1:0] mode_i;
  logic [NC-1:0]      clr_i;
  logic [NC-1:0]      level_o, rise_o, fall_o, pend_o;
  logic               irq_o;

  gnrc_edge_event #(
    .NUM_CH(NC), .FILT_CYCLES(F), .SYNC_STAGES(2), .RST_VAL(RSTV)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .d_i(d_i), .mode_i(mode_i), .clr_i(clr_i),
    .level_o(level_o), .rise_o(rise_o), .fall_o(fall_o), .pend_o(pend_o), .irq_o(irq_o)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- reference model ----------------
  // raw sample = d_i from S edges ago; level flips once raw has disagreed for F+1 edges.
  logic [NC-1:0] m_dpipe[$];
  logic [NC-1:0] m_level, m_rise, m_fall, m_pend;
  int            m_edge = 0;
  int            m_last_ok[NC];

  task automatic model_reset();
    m_dpipe.delete();
    for (int i = 0; i < S; i++) m_dpipe.push_back(RSTV);
    m_level = RSTV;
    m_rise  = '0;
    m_fall  = '0;
    m_pend  = '0;
    for (int c = 0; c < NC; c++) m_last_ok[c] = m_edge;
  endtask

  task automatic model_edge();
    logic [NC-1:0] raw, set;
    m_edge++;
    m_dpipe.push_back(d_i);
    raw = m_dpipe.pop_front();
    for (int c = 0; c < NC; c++) begin
      set[c] = (m_rise[c] && mode_i[c][0]) || (m_fall[c] && mode_i[c][1]);
    end
    m_pend = set | (m_pend & ~clr_i);
    m_rise = '0;
    m_fall = '0;
    for (int c = 0; c < NC; c++) begin
      if (raw[c] == m_level[c]) begin
        m_last_ok[c] = m_edge;
      end else if (m_edge - m_last_ok[c] > F) begin
        m_level[c]   = raw[c];
        m_rise[c]    = raw[c];
        m_fall[c]    = ~raw[c];
        m_last_ok[c] = m_edge;
      end
    end
  endtask

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("level", 32'(level_o), 32'(m_level));
    check("rise",  32'(rise_o),  32'(m_rise));
    check("fall",  32'(fall_o),  32'(m_fall));
    check("pend",  32'(pend_o),  32'(m_pend));
    check("irq",   32'(irq_o),   32'(|m_pend));
    check("rise_and_fall", 32'(rise_o & fall_o), 32'(0));
  endtask

  task automatic tick();
    @(posedge clk_i);
    if (!rst_ni) model_reset();
    else model_edge();
    @(negedge clk_i);
    compare_all();
  endtask

  task automatic settle(input int n);
    clr_i = '1;
    tick();
    clr_i = '0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_all_modes(input edge_mode_e m);
    for (int c = 0; c < NC; c++) mode_i[c] = m;
  endtask

  // ---------------- table ----------------
  typedef struct {
    int         ch;
    int         width;
    edge_mode_e mode;
    int         exp_rise;
    int         exp_fall;
    logic       exp_pend;
  } vec_t;

  vec_t vecs[9];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rises, falls, at, hold[NC];
    logic seen, fall_before;

    vecs[0] = '{1, 1,  EDGE_BOTH, 0, 0, 1'b0};
    vecs[1] = '{1, 3,  EDGE_BOTH, 0, 0, 1'b0};
    vecs[2] = '{1, 4,  EDGE_BOTH, 1, 1, 1'b1};
    vecs[3] = '{2, 6,  EDGE_FALL, 1, 1, 1'b1};
    vecs[4] = '{2, 6,  EDGE_NONE, 1, 1, 1'b0};
    vecs[5] = '{4, 10, EDGE_RISE, 1, 1, 1'b1};
    vecs[6] = '{5, 2,  EDGE_RISE, 0, 0, 1'b0};
    vecs[7] = '{6, 5,  EDGE_BOTH, 1, 1, 1'b1};
    vecs[8] = '{7, 3,  EDGE_RISE, 0, 0, 1'b0};

    rst_ni = 1'b0;
    d_i    = '0;
    clr_i  = '0;
    set_all_modes(EDGE_NONE);
    model_reset();
    for (int i = 0; i < 3; i++) tick();
    rst_ni = 1'b1;

    // Test 1a: quiet release, everything stays low.
    set_all_modes(EDGE_BOTH);
    for (int i = 0; i < 20; i++) begin
      tick();
      check("t1_quiet", 32'({level_o, rise_o, fall_o, pend_o, irq_o}), 32'(0));
    end

    // Table: glitch widths and mode selection on single channels.
    for (int v = 0; v < 9; v++) begin
      mode_i[vecs[v].ch] = vecs[v].mode;
      settle(2);
      rises = 0;
      falls = 0;
      d_i[vecs[v].ch] = 1'b1;
      for (int i = 0; i < vecs[v].width; i++) begin
        tick();
        rises += int'(rise_o[vecs[v].ch]);
        falls += int'(fall_o[vecs[v].ch]);
      end
      d_i[vecs[v].ch] = 1'b0;
      for (int i = 0; i < LAT + F + 4; i++) begin
        tick();
        rises += int'(rise_o[vecs[v].ch]);
        falls += int'(fall_o[vecs[v].ch]);
      end
      check("tbl_rise_cnt", 32'(rises), 32'(vecs[v].exp_rise));
      check("tbl_fall_cnt", 32'(falls), 32'(vecs[v].exp_fall));
      check("tbl_pend", 32'(pend_o[vecs[v].ch]), 32'(vecs[v].exp_pend));
    end

    // Test 3: EDGE_FALL sets pend only the cycle after fall_o.
    set_all_modes(EDGE_NONE);
    mode_i[2] = EDGE_FALL;
    settle(2);
    rises = 0;
    falls = 0;
    fall_before = 1'b0;
    d_i[2] = 1'b1;
    for (int i = 0; i < 8 + LAT + 6; i++) begin
      if (i == 8) d_i[2] = 1'b0;
      tick();
      check("t3_pend", 32'(pend_o[2]), 32'(fall_before));
      check("t3_irq", 32'(irq_o), 32'(fall_before));
      rises += int'(rise_o[2]);
      falls += int'(fall_o[2]);
      if (fall_o[2]) fall_before = 1'b1;
    end
    check("t3_rise_cnt", 32'(rises), 32'(1));
    check("t3_fall_cnt", 32'(falls), 32'(1));

    // Test 4: clear racing a set, then a lone clear.
    set_all_modes(EDGE_NONE);
    mode_i[3] = EDGE_RISE;
    settle(2);
    d_i[3] = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < LAT + 4 && !seen; i++) begin
      tick();
      seen = rise_o[3];
    end
    check("t4_rise_seen", 32'(seen), 32'(1));
    clr_i[3] = 1'b1;
    tick();
    check("t4_set_wins", 32'(pend_o[3]), 32'(1));
    tick();
    check("t4_clr_pend", 32'(pend_o[3]), 32'(0));
    check("t4_clr_irq", 32'(irq_o), 32'(0));
    clr_i[3] = 1'b0;
    d_i[3] = 1'b0;
    settle(LAT + F + 2);

    // Test 1b: input high through reset gives one rise exactly LAT edges after release.
    #2;
    rst_ni = 1'b0;
    d_i = 8'h01;
    set_all_modes(EDGE_BOTH);
    for (int i = 0; i < 3; i++) tick();
    rst_ni = 1'b1;
    rises = 0;
    at = -1;
    for (int k = 1; k <= LAT + 10; k++) begin
      tick();
      if (rise_o[0]) begin
        rises++;
        if (at < 0) at = k;
      end
    end
    check("t1_rise_edge", 32'(at), 32'(LAT));
    check("t1_rise_once", 32'(rises), 32'(1));
    d_i = '0;
    settle(2 * LAT + 4);

    // Test 5: all channels rise together.
    d_i = '1;
    seen = 1'b0;
    at = 0;
    for (int i = 0; i < LAT + 4 && !seen; i++) begin
      tick();
      at++;
      seen = |rise_o;
    end
    check("t5_latency", 32'(at), 32'(LAT));
    check("t5_all_rise", 32'(rise_o), 32'(8'hFF));
    tick();
    check("t5_pend_all", 32'(pend_o), 32'(8'hFF));
    check("t5_irq", 32'(irq_o), 32'(1));

    // Test 6: async reset while the filter is mid-count, pend still set.
    d_i = '0;
    for (int i = 0; i < 2 * LAT + 4; i++) tick();
    d_i = '1;
    for (int i = 0; i < S + 2; i++) tick();
    check("t6_pre_pend", 32'(pend_o), 32'(8'hFF));
    #2;
    rst_ni = 1'b0;
    #1;
    check("t6_async_out", 32'({level_o, rise_o, fall_o, pend_o, irq_o}), 32'(0));
    d_i = '0;
    for (int i = 0; i < 2; i++) tick();
    rst_ni = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("t6_no_pulse", 32'({rise_o, fall_o, pend_o}), 32'(0));
    end

    // Randomised phase against the model.
    for (int c = 0; c < NC; c++) hold[c] = $urandom_range(1, 8);
    for (int n = 0; n < 1500; n++) begin
      for (int c = 0; c < NC; c++) begin
        hold[c]--;
        if (hold[c] <= 0) begin
          d_i[c]  = ~d_i[c];
          hold[c] = $urandom_range(1, 8);
        end
        if ($urandom_range(0, 15) == 0) mode_i[c] = 2'($urandom_range(0, 3));
        clr_i[c] = ($urandom_range(0, 9) == 0);
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
